// File: rtl/accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : accuracy_monitor
// Purpose  : Classification accuracy tally. Compares each predicted class with
//            its ground-truth label on every accepted sample strobe and keeps
//            total/correct/invalid counts plus per-class seen/hit counts.
//            A run stops by itself after N_SAMPLES accepted samples.
// Ports    : clk            - rising-edge clock
//            rst            - synchronous reset, active low
//            start_i        - one-cycle pulse: clear all counts, (re)start run
//            pred_valid_i   - sample strobe for pred_class_i / label_i
//            pred_class_i   - network result
//            label_i        - ground-truth class of the same sample
//            rd_class_i     - per-class counter read index
//            busy_o         - run in progress
//            done_o         - budget reached, held until start or reset
//            total_count_o  - samples accepted this run
//            correct_count_o- in-range samples with pred == label
//            invalid_count_o- samples with label or pred out of range
//            rd_seen_o      - seen count of rd_class_i (one cycle later)
//            rd_hits_o      - hit count of rd_class_i (one cycle later)
// Revision : 1.0 - initial release
// ============================================================================
module accuracy_monitor #(
  parameter int CLASS_W   = 8,
  parameter int N_CLASSES = 10,
  parameter int CNT_W     = 10,
  parameter int N_SAMPLES = 750
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               pred_valid_i,
  input  logic [CLASS_W-1:0] pred_class_i,
  input  logic [CLASS_W-1:0] label_i,
  input  logic [CLASS_W-1:0] rd_class_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   total_count_o,
  output logic [CNT_W-1:0]   correct_count_o,
  output logic [CNT_W-1:0]   invalid_count_o,
  output logic [CNT_W-1:0]   rd_seen_o,
  output logic [CNT_W-1:0]   rd_hits_o
);

  // One extra bit so N_CLASSES == 2^CLASS_W stays representable.
  localparam logic [CLASS_W:0]  c_NCLS = (CLASS_W+1)'(N_CLASSES);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  c_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] total_q, correct_q, invalid_q;
  logic [CNT_W-1:0] seen_q [N_CLASSES];
  logic [CNT_W-1:0] hits_q [N_CLASSES];
  logic [CNT_W-1:0] rd_seen_q, rd_hits_q;
  logic [CNT_W-1:0] rd_seen_d, rd_hits_d;

  logic w_accept, w_in_range, w_valid_acc, w_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_ONE;
  endfunction

  // start always wins over a coincident sample.
  assign w_accept    = (state_q == S_RUN) && pred_valid_i && !start_i;
  assign w_in_range  = ({1'b0, label_i} < c_NCLS) && ({1'b0, pred_class_i} < c_NCLS);
  assign w_valid_acc = w_accept && w_in_range;
  assign w_hit       = w_valid_acc && (pred_class_i == label_i);

  // --------------------------------------------------------------------------
  // Run-control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      // A start in RUN keeps RUN (w_accept is low then), counters clear below.
      S_RUN:   if (w_accept && (total_q == c_LAST)) state_d = S_DONE;
      S_DONE:  if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Global counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst || start_i) begin
      total_q   <= '0;
      correct_q <= '0;
      invalid_q <= '0;
    end else if (w_accept) begin
      total_q <= sat_inc(total_q);
      if (!w_in_range) invalid_q <= sat_inc(invalid_q);
      if (w_hit)       correct_q <= sat_inc(correct_q);
    end
  end

  // --------------------------------------------------------------------------
  // Per-class counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst || start_i) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        seen_q[i] <= '0;
        hits_q[i] <= '0;
      end
    end else if (w_valid_acc) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        if (label_i == CLASS_W'(i)) begin
          seen_q[i] <= sat_inc(seen_q[i]);
          if (w_hit) hits_q[i] <= sat_inc(hits_q[i]);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port; out-of-range indices match no entry and read 0.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_seen_d = '0;
    rd_hits_d = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (rd_class_i == CLASS_W'(i)) begin
        rd_seen_d = seen_q[i];
        rd_hits_d = hits_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_seen_q <= '0;
      rd_hits_q <= '0;
    end else begin
      rd_seen_q <= rd_seen_d;
      rd_hits_q <= rd_hits_d;
    end
  end

  assign busy_o          = (state_q == S_RUN);
  assign done_o          = (state_q == S_DONE);
  assign total_count_o   = total_q;
  assign correct_count_o = correct_q;
  assign invalid_count_o = invalid_q;
  assign rd_seen_o       = rd_seen_q;
  assign rd_hits_o       = rd_hits_q;

endmodule
`default_nettype wire

// File: tb/tb_accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_accuracy_monitor
// Purpose  : Self-checking bench for accuracy_monitor. Two instances share one
//            stimulus stream: A (10 classes, 10-bit counters, 4-sample budget)
//            and B (2 classes, 3-bit counters, 7-sample budget). A reference
//            tally per instance predicts the outputs; a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accuracy_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pred_valid = 1'b0;
  logic [7:0] pred_class = '0;
  logic [7:0] label = '0;
  logic [7:0] rd_class = '0;

  logic       a_busy, a_done, b_busy, b_done;
  logic [9:0] a_total, a_correct, a_invalid, a_seen, a_hits;
  logic [2:0] b_total, b_correct, b_invalid, b_seen, b_hits;

  always #5 clk = ~clk;

  accuracy_monitor #(.CLASS_W(8), .N_CLASSES(10), .CNT_W(10), .N_SAMPLES(4)) u_a (
    .clk(clk), .rst(rst), .start_i(start), .pred_valid_i(pred_valid),
    .pred_class_i(pred_class), .label_i(label), .rd_class_i(rd_class),
    .busy_o(a_busy), .done_o(a_done), .total_count_o(a_total),
    .correct_count_o(a_correct), .invalid_count_o(a_invalid),
    .rd_seen_o(a_seen), .rd_hits_o(a_hits));

  accuracy_monitor #(.CLASS_W(8), .N_CLASSES(2), .CNT_W(3), .N_SAMPLES(7)) u_b (
    .clk(clk), .rst(rst), .start_i(start), .pred_valid_i(pred_valid),
    .pred_class_i(pred_class), .label_i(label), .rd_class_i(rd_class),
    .busy_o(b_busy), .done_o(b_done), .total_count_o(b_total),
    .correct_count_o(b_correct), .invalid_count_o(b_invalid),
    .rd_seen_o(b_seen), .rd_hits_o(b_hits));

  typedef struct {
    int busy, done, total, correct, invalid, seen, hits;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference tally: phase 0 = not running, 1 = counting, 2 = budget reached.
  int m_phase [2];
  int m_tot   [2];
  int m_cor   [2];
  int m_inv   [2];
  int m_seen  [2][256];
  int m_hits  [2][256];

  function automatic int bump(int v, int cmax);
    return (v < cmax) ? v + 1 : v;
  endfunction

  function automatic exp_t model_step(int k, int ncls, int nsamp, int cmax,
                                      bit r, bit st, bit pv, int pc, int lb, int rc);
    exp_t e;
    // Read port shows the tally as it stood before this cycle's update.
    e.seen = (r && rc < ncls) ? m_seen[k][rc] : 0;
    e.hits = (r && rc < ncls) ? m_hits[k][rc] : 0;
    if (!r || st) begin
      m_tot[k] = 0; m_cor[k] = 0; m_inv[k] = 0;
      for (int i = 0; i < 256; i++) begin
        m_seen[k][i] = 0;
        m_hits[k][i] = 0;
      end
      m_phase[k] = r ? 1 : 0;
    end else if (m_phase[k] == 1 && pv) begin
      m_tot[k] = bump(m_tot[k], cmax);
      if (lb < ncls && pc < ncls) begin
        m_seen[k][lb] = bump(m_seen[k][lb], cmax);
        if (pc == lb) begin
          m_cor[k]      = bump(m_cor[k], cmax);
          m_hits[k][lb] = bump(m_hits[k][lb], cmax);
        end
      end else begin
        m_inv[k] = bump(m_inv[k], cmax);
      end
      if (m_tot[k] == nsamp) m_phase[k] = 2;
    end
    e.busy    = (m_phase[k] == 1) ? 1 : 0;
    e.done    = (m_phase[k] == 2) ? 1 : 0;
    e.total   = m_tot[k];
    e.correct = m_cor[k];
    e.invalid = m_inv[k];
    return e;
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue what each
  // instance should show after the following rising edge.
  task automatic step(input bit r, input bit st, input bit pv,
                      input int pc, input int lb, input int rc);
    @(negedge clk);
    rst        = r;
    start      = st;
    pred_valid = pv;
    pred_class = 8'(pc);
    label      = 8'(lb);
    rd_class   = 8'(rc);
    qa.push_back(model_step(0, 10, 4, 1023, r, st, pv, pc, lb, rc));
    qb.push_back(model_step(1, 2, 7, 7, r, st, pv, pc, lb, rc));
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  // Monitor: outputs sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("A.busy",    int'(a_busy),    e.busy);
        chk("A.done",    int'(a_done),    e.done);
        chk("A.total",   int'(a_total),   e.total);
        chk("A.correct", int'(a_correct), e.correct);
        chk("A.invalid", int'(a_invalid), e.invalid);
        chk("A.rd_seen", int'(a_seen),    e.seen);
        chk("A.rd_hits", int'(a_hits),    e.hits);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("B.busy",    int'(b_busy),    e.busy);
        chk("B.done",    int'(b_done),    e.done);
        chk("B.total",   int'(b_total),   e.total);
        chk("B.correct", int'(b_correct), e.correct);
        chk("B.invalid", int'(b_invalid), e.invalid);
        chk("B.rd_seen", int'(b_seen),    e.seen);
        chk("B.rd_hits", int'(b_hits),    e.hits);
      end
    end
  end

  initial begin
    int pc, lb, w;
    // Reset for two cycles, then stray strobes with no start.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 3, 3);
    for (int i = 0; i < 5; i++) step(1, 0, 1, i, i, i);

    // Basic run: (3,3),(1,2),(7,7),(7,7), then read classes 7 and 2.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 3, 7);
    step(1, 0, 1, 1, 2, 7);
    step(1, 0, 1, 7, 7, 7);
    step(1, 0, 1, 7, 7, 7);
    step(1, 0, 0, 0, 0, 7);
    step(1, 0, 0, 0, 0, 2);
    step(1, 0, 0, 0, 0, 3);
    // Extra strobes after done are ignored.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 1);

    // New run with out-of-range samples.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 12, 12, 12);
    step(1, 0, 1, 0, 15, 0);
    step(1, 0, 0, 0, 0, 0);

    // start coincident with a sample in RUN: sample dropped, counts cleared.
    step(1, 0, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 1);

    // Reset mid-run after two samples.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Seven correct class-0 samples fill B's 3-bit counters to the top.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 5);
    step(1, 0, 0, 0, 0, 5);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      pc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) pc = 255;
      lb = ($urandom_range(0, 1) == 0) ? pc : int'($urandom_range(0, 12));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), pc, lb, int'($urandom_range(0, 12)));
    end
    step(1, 0, 0, 0, 0, 0);

    w = 0;
    while ((qa.size() > 0 || qb.size() > 0) && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
